// File: rtl/dsq_issuer.sv
// dsq_issuer: PCPI initiator streaming packed pixel-pair words into the dsq
// coprocessor and accumulating the returned distance-squared running sum.
//
// Ports:
//   clk, resetn           clock, async active-low reset
//   start, len            job request (IDLE only) and word count
//   in_valid/in_data/in_ready   stream of {x1, x1_d, x2, x2_d} words
//   pcpi_valid/instr/rs1/rs2    request to dsq (rs2 = running sum)
//   pcpi_ready/wait/rd/wr       response from dsq
//   busy, done, result, err     job status; result/err presented with done
//
// Optional: define DSQ_TIMEOUT_EN to abandon a job whose ISSUE phase sees no
// pcpi_ready for TIMEOUT_CYCLES cycles while pcpi_wait is low.

module dsq_issuer #(
    parameter logic [31:0] INSTR          = 32'h0200_000B,
    parameter int          LEN_W          = 16,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_instr,
    output logic [31:0]      pcpi_rs1,
    output logic [31:0]      pcpi_rs2,
    input  logic             pcpi_ready,
    input  logic             pcpi_wait,
    input  logic [31:0]      pcpi_rd,
    input  logic             pcpi_wr,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [31:0]      acc;
    logic             err_q;

`ifdef DSQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0] tcnt;
`else
    logic unused_wait;
    assign unused_wait = pcpi_wait;
`endif

    assign pcpi_instr = INSTR;
    assign in_ready   = (state == S_FETCH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            remaining  <= '0;
            acc        <= '0;
            err_q      <= 1'b0;
            pcpi_valid <= 1'b0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
`ifdef DSQ_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        err_q <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        if (len != '0) begin
                            remaining <= len;
                            state     <= S_FETCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        pcpi_rs1   <= in_data;
                        pcpi_rs2   <= acc;
                        pcpi_valid <= 1'b1;
`ifdef DSQ_TIMEOUT_EN
                        tcnt       <= '0;
`endif
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (pcpi_ready) begin
                        // A response without write-back is an anomaly: keep
                        // the sum, flag the job.
                        if (pcpi_wr) begin
                            acc <= pcpi_rd;
                        end else begin
                            err_q <= 1'b1;
                        end
                        pcpi_valid <= 1'b0;
                        remaining  <= remaining - LEN_W'(1);
                        state      <= (remaining == LEN_W'(1)) ? S_DONE : S_FETCH;
                    end
`ifdef DSQ_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Saturated: a busy responder keeps the job alive,
                        // an idle one gets abandoned.
                        if (!pcpi_wait) begin
                            pcpi_valid <= 1'b0;
                            err_q      <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                S_DONE: begin
                    done   <= 1'b1;
                    result <= acc;
                    err    <= err_q;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsq_issuer.sv
// tb_dsq_issuer: directed self-checking bench for dsq_issuer with a
// behavioural dsq responder (configurable ready delay / missing write-back).

module tb_dsq_issuer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        pcpi_valid;
    logic [31:0] pcpi_instr;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_ready;
    logic        pcpi_wait;
    logic [31:0] pcpi_rd;
    logic        pcpi_wr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int nchk = 0;
    int nfail = 0;

    int rdy_delay = 0;
    int nowr_at = -1;
    bit never_ready = 1'b0;
    bit wait_hi = 1'b0;

    int vcnt = 0;
    int wcnt = 0;
    int wbase = 0;
    int consumed = 0;
    int unstable = 0;
    bit hold = 1'b0;
    logic [31:0] h_rs1, h_rs2;
    logic [31:0] rs2q[$];
    logic [31:0] words[0:7];

    always #5 clk = ~clk;

    dsq_issuer dut (
        .clk(clk), .resetn(resetn), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pcpi_valid(pcpi_valid), .pcpi_instr(pcpi_instr),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_ready(pcpi_ready), .pcpi_wait(pcpi_wait),
        .pcpi_rd(pcpi_rd), .pcpi_wr(pcpi_wr),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    function automatic logic [31:0] dsq(input logic [31:0] a, input logic [31:0] s);
        int d1, d2;
        d1 = int'(a[31:24]) - int'(a[23:16]);
        d2 = int'(a[15:8]) - int'(a[7:0]);
        return s + 32'(d1 * d1) + 32'(d2 * d2);
    endfunction

    always_comb begin
        pcpi_ready = pcpi_valid && !never_ready && (vcnt >= rdy_delay);
        pcpi_wr    = ((wcnt - wbase) != nowr_at);
        pcpi_rd    = dsq(pcpi_rs1, pcpi_rs2);
        pcpi_wait  = wait_hi;
    end

    always @(posedge clk) begin
        vcnt <= (pcpi_valid && !pcpi_ready) ? vcnt + 1 : 0;
        if (pcpi_valid && pcpi_ready) begin
            wcnt <= wcnt + 1;
            rs2q.push_back(pcpi_rs2);
        end
        if (in_valid && in_ready) consumed <= consumed + 1;
        if (hold && resetn &&
            (!pcpi_valid || pcpi_rs1 !== h_rs1 || pcpi_rs2 !== h_rs2))
            unstable <= unstable + 1;
        hold  <= pcpi_valid && !pcpi_ready;
        h_rs1 <= pcpi_rs1;
        h_rs2 <= pcpi_rs2;
    end

    task automatic do_job(input int n, input int gap, input bit poke,
                          output logic [31:0] res, output logic e);
        int t;
        wbase = wcnt;
        @(negedge clk);
        start = 1'b1;
        len = 16'(n);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data = words[i];
            t = 0;
            while (!in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            if (poke && i == 0) begin
                start = 1'b1;
                len = 16'd1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        nchk++;
        if (done !== 1'b1) begin
            nfail++;
            $display("FAIL job_done: done=%b want 1 (timeout)", done);
        end
        res = result;
        e = err;
    endtask

    task automatic test_reset;
        nchk++; if (pcpi_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %b want 0", pcpi_valid); end
        nchk++; if (pcpi_instr !== 32'h0200_000B) begin nfail++; $display("FAIL rst_instr: got %h want 0200000b", pcpi_instr); end
        nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %b want 0", busy); end
        nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL rst_done: got %b want 0", done); end
        nchk++; if (result !== 32'd0) begin nfail++; $display("FAIL rst_result: got %0d want 0", result); end
        nchk++; if (err !== 1'b0 || in_ready !== 1'b0) begin nfail++; $display("FAIL rst_err_ready: got %b%b want 00", err, in_ready); end
        nchk++; if (pcpi_rs1 !== 32'd0 || pcpi_rs2 !== 32'd0) begin nfail++; $display("FAIL rst_rs: got %h %h want 0 0", pcpi_rs1, pcpi_rs2); end
    endtask

    task automatic test_single;
        bit early = 1'b0;
        rdy_delay = 0;
        in_data = 32'h0A07_0503;
        in_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        len = 16'd1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k < 4 && done) early = 1'b1;
            if (k == 2) begin
                nchk++; if (!(pcpi_valid === 1'b1 && pcpi_ready === 1'b1)) begin nfail++; $display("FAIL single_issue: valid=%b ready=%b want 1 1", pcpi_valid, pcpi_ready); end
                nchk++; if (pcpi_rs2 !== 32'd0) begin nfail++; $display("FAIL single_rs2: got %0d want 0", pcpi_rs2); end
                in_valid = 1'b0;
            end
            if (k == 4) begin
                nchk++; if (done !== 1'b1 || early) begin nfail++; $display("FAIL single_latency: done=%b early=%b want 1 0", done, early); end
                nchk++; if (result !== 32'd13) begin nfail++; $display("FAIL single_result: got %0d want 13", result); end
                nchk++; if (err !== 1'b0) begin nfail++; $display("FAIL single_err: got %b want 0", err); end
            end
            if (k == 5) begin
                nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL single_pulse: done=%b want 0", done); end
            end
        end
    endtask

    task automatic test_three;
        logic [31:0] r;
        logic e;
        int qb;
        qb = rs2q.size();
        rdy_delay = 0;
        do_job(3, 0, 1'b0, r, e);
        nchk++; if (rs2q.size() != qb + 3) begin nfail++; $display("FAIL three_count: got %0d want 3", rs2q.size() - qb); end
        else begin
            nchk++; if (rs2q[qb] !== 32'd0 || rs2q[qb+1] !== 32'd13 || rs2q[qb+2] !== 32'd26) begin
                nfail++; $display("FAIL three_rs2: got %0d %0d %0d want 0 13 26", rs2q[qb], rs2q[qb+1], rs2q[qb+2]);
            end
        end
        nchk++; if (r !== 32'd130076) begin nfail++; $display("FAIL three_result: got %0d want 130076", r); end
        nchk++; if (e !== 1'b0) begin nfail++; $display("FAIL three_err: got %b want 0", e); end
    endtask

    task automatic test_stall;
        logic [31:0] r;
        logic e;
        int cb, ub;
        cb = consumed;
        ub = unstable;
        rdy_delay = 5;
        do_job(3, 3, 1'b0, r, e);
        rdy_delay = 0;
        nchk++; if (unstable != ub) begin nfail++; $display("FAIL stall_stable: got %0d changes want 0", unstable - ub); end
        nchk++; if (consumed - cb != 3) begin nfail++; $display("FAIL stall_consumed: got %0d want 3", consumed - cb); end
        nchk++; if (r !== 32'd130076) begin nfail++; $display("FAIL stall_result: got %0d want 130076", r); end
        nchk++; if (e !== 1'b0) begin nfail++; $display("FAIL stall_err: got %b want 0", e); end
    endtask

    task automatic test_len0;
        @(negedge clk);
        start = 1'b1;
        len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        nchk++; if (done !== 1'b0 || busy !== 1'b1) begin nfail++; $display("FAIL len0_busy: done=%b busy=%b want 0 1", done, busy); end
        @(negedge clk);
        nchk++; if (done !== 1'b1 || result !== 32'd0 || err !== 1'b0) begin
            nfail++; $display("FAIL len0_done: done=%b result=%0d err=%b want 1 0 0", done, result, err);
        end
    endtask

    task automatic test_busy_start;
        logic [31:0] r;
        logic e;
        int cb;
        bit extra = 1'b0;
        cb = consumed;
        do_job(3, 0, 1'b1, r, e);
        nchk++; if (r !== 32'd130076) begin nfail++; $display("FAIL busy_result: got %0d want 130076", r); end
        nchk++; if (consumed - cb != 3) begin nfail++; $display("FAIL busy_consumed: got %0d want 3", consumed - cb); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        nchk++; if (extra) begin nfail++; $display("FAIL busy_extra_job: got 1 want 0"); end
    endtask

    task automatic test_nowr;
        logic [31:0] r;
        logic e;
        nowr_at = 1;
        do_job(3, 0, 1'b0, r, e);
        nowr_at = -1;
        nchk++; if (e !== 1'b1) begin nfail++; $display("FAIL nowr_err: got %b want 1", e); end
        nchk++; if (r !== 32'd130063) begin nfail++; $display("FAIL nowr_result: got %0d want 130063", r); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic e;
        int t = 0;
        rdy_delay = 20;
        @(negedge clk);
        start = 1'b1;
        len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = words[0];
        while (!pcpi_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        nchk++; if (pcpi_valid !== 1'b1) begin nfail++; $display("FAIL rmid_issue: valid=%b want 1", pcpi_valid); end
        #2 resetn = 1'b0;
        #1;
        nchk++; if (pcpi_valid !== 1'b0) begin nfail++; $display("FAIL rmid_valid: got %b want 0", pcpi_valid); end
        nchk++; if (busy !== 1'b0 || result !== 32'd0) begin nfail++; $display("FAIL rmid_state: busy=%b result=%0d want 0 0", busy, result); end
        @(negedge clk);
        resetn = 1'b1;
        rdy_delay = 0;
        do_job(3, 0, 1'b0, r, e);
        nchk++; if (r !== 32'd130076 || e !== 1'b0) begin nfail++; $display("FAIL rmid_fresh: result=%0d err=%b want 130076 0", r, e); end
    endtask

`ifdef DSQ_TIMEOUT_EN
    task automatic test_timeout;
        int t = 0;
        int vc = 0;
        int cb;
        cb = consumed;
        never_ready = 1'b1;
        wait_hi = 1'b0;
        @(negedge clk);
        start = 1'b1;
        len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = words[0];
        @(negedge clk);
        in_valid = 1'b0;
        while (!done && t < 200) begin
            if (pcpi_valid) vc++;
            @(negedge clk);
            t++;
        end
        nchk++; if (done !== 1'b1 || err !== 1'b1) begin nfail++; $display("FAIL to_done: done=%b err=%b want 1 1", done, err); end
        nchk++; if (vc != 64) begin nfail++; $display("FAIL to_cycles: got %0d want 64", vc); end
        nchk++; if (consumed - cb != 1) begin nfail++; $display("FAIL to_consumed: got %0d want 1", consumed - cb); end
        wait_hi = 1'b1;
        @(negedge clk);
        start = 1'b1;
        len = 16'd3;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        nchk++; if (done !== 1'b0 || pcpi_valid !== 1'b1) begin nfail++; $display("FAIL to_wait: done=%b valid=%b want 0 1", done, pcpi_valid); end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        never_ready = 1'b0;
        wait_hi = 1'b0;
    endtask
`endif

    initial begin
        words[0] = 32'h0A07_0503;
        words[1] = 32'h070A_0305;
        words[2] = 32'hFF00_00FF;
        for (int i = 3; i < 8; i++) words[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        test_single();
        test_three();
        test_stall();
        test_len0();
        test_busy_start();
        test_nowr();
        test_reset_mid();
`ifdef DSQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/dsq_issuer.md
Name: dsq_issuer

Overview:
PCPI-style initiator that drives the dsq distance-squared coprocessor. It takes a stream of packed pixel-pair words {x1, x1_d, x2, x2_d} and issues one dsq transaction per word, feeding the running sum back as rs2. When the programmed element count has been issued, it presents the final sum. It sits between a feature/pixel stream source and the dsq responder, so the core is not needed for vector distance loops.

Parameters:
INSTR, 32'h0200_000B, value driven on pcpi_instr (custom-0 dsq encoding)
LEN_W, 16, width of element-count input and internal remaining counter
TIMEOUT_CYCLES, 64, max cycles in ISSUE without pcpi_ready (used only with DSQ_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  job request pulse; sampled only in IDLE
len  in  LEN_W  number of words in the job; latched on accepted start
in_valid  in  1  stream word valid
in_data  in  32  packed word {x1, x1_d, x2, x2_d}
in_ready  out  1  stream word accepted when in_valid & in_ready
pcpi_valid  out  1  transaction request to dsq
pcpi_instr  out  32  instruction word, constant INSTR
pcpi_rs1  out  32  captured stream word
pcpi_rs2  out  32  running accumulator
pcpi_ready  in  1  dsq result valid
pcpi_wait  in  1  dsq busy hint; informational only, except for the timeout (see Optional Feature)
pcpi_rd  in  32  dsq result (rs2 + sq1 + sq2)
pcpi_wr  in  1  dsq writes rd
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of job
result  out  32  final accumulator; holds until next accepted start
err  out  1  valid with done; high if any anomaly occurred in the job

Behaviour:
- Reset values: every output is 0, except pcpi_instr = INSTR; acc = 0; state = IDLE. Reset acts immediately, including mid-job; pcpi_valid drops asynchronously.
- States: IDLE, FETCH, ISSUE, DONE. All outputs are registered except in_ready, which is (state == FETCH).
- IDLE:
  - start & len != 0 -> latch remaining = len, clear acc and err, go to FETCH.
  - start & len == 0 -> go to DONE with result 0, err 0.
- FETCH: on in_valid & in_ready, pcpi_rs1 <= in_data, pcpi_rs2 <= acc, pcpi_valid <= 1, go to ISSUE. Exactly one word is consumed per element.
- ISSUE:
  - pcpi_valid, pcpi_rs1, pcpi_rs2 and pcpi_instr are held stable until the cycle in which pcpi_ready = 1 is sampled.
  - A combinational responder may raise ready in the same cycle valid first appears; that counts.
  - On ready & wr: acc <= pcpi_rd.
  - On ready & !wr: acc unchanged, err sticky set.
  - Either way, pcpi_valid <= 0 on the next edge and remaining decrements.
  - If remaining was 1, go to DONE; else go to FETCH.
  - Minimum issue period is 2 cycles per word (FETCH + ISSUE).
- DONE: done = 1 for exactly one cycle, result <= acc, err presented. Return to IDLE.
- start asserted in any state other than IDLE is ignored, including in DONE.
- Arithmetic: accumulation is performed by dsq. acc is 32 bits and wraps modulo 2^32 with no saturation.
- Result latency for a 1-word job with a zero-wait responder: start accepted at edge 0; word accepted at edge 1 if in_valid is already high; ISSUE ready sampled at edge 2; DONE at edge 3, done high in cycle 3.

Optional Feature:
- Macro: DSQ_TIMEOUT_EN.
- When defined:
  - A counter clears on ISSUE entry and increments each ISSUE cycle without pcpi_ready.
  - On reaching TIMEOUT_CYCLES with pcpi_wait high, the counter holds instead of firing (the responder is still busy).
  - On reaching TIMEOUT_CYCLES with pcpi_wait low: drop pcpi_valid, set err, abandon the remaining words (not consumed), go to DONE with result = acc so far.
- When not defined: no counter is built, and ISSUE waits indefinitely for pcpi_ready.

Test Plan:
- Single word: len=1, in_data 0x0A070503, zero-wait responder -> done one cycle later with result 13, err 0; pcpi_rs2 was 0 during the transaction.
- Three-word accumulate: 0x0A070503, 0x070A0305, 0xFF0000FF -> pcpi_rs2 sequence 0, 13, 26; result 130076, err 0.
- Stalls: responder ready delayed 5 cycles, in_valid gapped for 3 cycles -> pcpi_rs1/rs2/valid stable throughout the delay, no extra word consumed, result identical to the zero-wait run.
- Edge and illegal cases:
  - len=0 -> done the cycle after start with result 0.
  - start pulsed while busy -> ignored, len not re-latched.
  - ready without wr on word 2 of 3 -> err 1, result excludes word 2's contribution.
- Reset mid-ISSUE (resetn low for 1 cycle) -> pcpi_valid 0 immediately, busy 0, result 0; a fresh job afterwards is correct.
- DSQ_TIMEOUT_EN: responder never asserts ready, pcpi_wait low, TIMEOUT_CYCLES=64 -> done with err 1 after 64 ISSUE cycles, remaining words not consumed. Same run with pcpi_wait held high -> no timeout fires.
